// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM states, default
// frame start byte and frame header length.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
    localparam int unsigned HDR_LEN       = 3;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and program-memory load port of the boot loader.
// The master side feeds bytes; the slave side is the loader itself.
interface boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  mem_load;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  err;

    modport master (
        output rx_data, rx_valid,
        input  mem_load, mem_addr, mem_wdata, cpu_rst, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_load, mem_addr, mem_wdata, cpu_rst, done, err
    );
endinterface

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT_CYCLES-1.
module boot_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/boot_loader.sv
// Frame-driven program loader: parses MAGIC/length/payload/checksum,
// writes little-endian words to program memory and gates the CPU reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    boot_loader_if.slave bus
);
    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  mem_load_q, mem_load_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  tmo_en, tmo_expired;
    logic [15:0]           n_words;

    boot_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (bus.rx_valid),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );

    assign tmo_en  = (state_q == LEN0) || (state_q == LEN1) ||
                     (state_q == DATA) || (state_q == CSUM);
    assign n_words = {bus.rx_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_load_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.rx_valid && bus.rx_data == MAGIC) begin
                    state_d   = LEN0;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    csum_d    = '0;
                end
            end
            LEN0: begin
                if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (bus.rx_valid) begin
                    len_d = n_words;
                    if (n_words == 16'd0) begin
                        state_d = CSUM;
                    end else if (32'(n_words) > (32'd1 << ADDR_WIDTH)) begin
                        state_d = ERROR;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    // Bytes enter at the top and shift down, so byte 0 ends in bits 7:0.
                    word_d     = {bus.rx_data, word_q[31:8]};
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_load_d  = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = word_d;
                        word_idx_d  = word_idx_q + 1'b1;
                        if (32'(word_idx_q) + 32'd1 == 32'(len_q)) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d   = DONE;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tmo_expired && !bus.rx_valid) begin
            state_d = ERROR;
        end
        // Every path into ERROR shares the same latched flag updates.
        if (state_d == ERROR && state_q != ERROR) begin
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            mem_load_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            mem_load_q  <= mem_load_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_load  = mem_load_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed frames plus random frames, checked every
// cycle against a byte-position frame model.
module tb_boot_loader;
    import boot_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned T  = 40;
    localparam logic [7:0]  MG = 8'hA5;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    boot_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T),
        .MAGIC         (MG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    wr_t         wlog[$];

    // Frame model: position of each byte after MAGIC decides its meaning.
    bit          m_in_frame, m_blind;
    int unsigned m_pos, m_len, m_s;
    logic [7:0]  m_lo, m_csum;
    logic [7:0]  m_word[4];
    logic        exp_mem_load, exp_cpu_rst, exp_done, exp_err;
    int unsigned exp_addr;
    logic [31:0] exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame   = 0;
        m_blind      = 0;
        m_pos        = 0;
        m_len        = 0;
        m_s          = 0;
        m_csum       = 8'h00;
        exp_mem_load = 1'b0;
        exp_cpu_rst  = 1'b1;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_addr     = 0;
        exp_wdata    = 32'h0;
    endtask

    task automatic model_fail();
        m_in_frame  = 0;
        m_blind     = 1;
        exp_err     = 1'b1;
        exp_cpu_rst = 1'b1;
        exp_done    = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        int unsigned k;
        int unsigned n;
        if (m_pos == 0) begin
            m_lo = d;
        end else if (m_pos == 1) begin
            n = {d, m_lo};
            if (n > (1 << AW)) model_fail();
            else m_len = n;
        end else begin
            k = m_pos - (HDR_LEN - 1);
            if (k < 4 * m_len) begin
                m_word[k % 4] = d;
                m_csum = m_csum ^ d;
                if (k % 4 == 3) begin
                    exp_mem_load = 1'b1;
                    exp_addr     = (k / 4) % (1 << AW);
                    exp_wdata    = {m_word[3], m_word[2], m_word[1], m_word[0]};
                end
            end else if (d == m_csum) begin
                m_in_frame  = 0;
                exp_cpu_rst = 1'b0;
                exp_done    = 1'b1;
            end else begin
                model_fail();
            end
        end
        m_pos++;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        exp_mem_load = 1'b0;
        if (!m_in_frame) begin
            if (m_blind) begin
                m_blind = 0;
            end else if (v && d == MG) begin
                m_in_frame  = 1;
                m_pos       = 0;
                m_s         = 0;
                m_csum      = 8'h00;
                exp_cpu_rst = 1'b1;
                exp_done    = 1'b0;
                exp_err     = 1'b0;
            end
        end else if (v) begin
            m_s = 0;
            model_byte(d);
        end else if (m_s == T - 1) begin
            model_fail();
        end else begin
            m_s++;
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        if (!rst) model_step(v, d);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int unsigned gap);
        tick(1'b1, d);
        repeat (gap) tick(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send(fr[i], (i == fr.size() - 1) ? 0 : 2);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("mem_load", bus.mem_load, exp_mem_load);
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_wdata", bus.mem_wdata, exp_wdata);
            chk("cpu_rst", bus.cpu_rst, exp_cpu_rst);
            chk("done", bus.done, exp_done);
            chk("err", bus.err, exp_err);
            if (bus.mem_load === 1'b1) wlog.push_back('{bus.mem_addr, bus.mem_wdata});
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [7:0]  fr[$];
        logic [7:0]  cs;
        int unsigned n, kind, cut;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        #12;
        chk("rst_cpu_rst", bus.cpu_rst, 1'b1);
        chk("rst_mem_load", bus.mem_load, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Good two-word frame
        wlog.delete();
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        send_frame(fr);
        chk("good_done_1cyc", bus.done, 1'b1);
        chk("good_cpu_rst_1cyc", bus.cpu_rst, 1'b0);
        chk("model_good_done", exp_done, 1'b1);
        idle(3);
        chk("good_wr_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("good_wr0_addr", wlog[0].addr, 0);
            chk("good_wr0_data", wlog[0].data, 32'h0000_0013);
            chk("good_wr1_addr", wlog[1].addr, 1);
            chk("good_wr1_data", wlog[1].data, 32'h0000_006F);
        end

        // Bad checksum
        fr[fr.size() - 1] = 8'h7D;
        send_frame(fr);
        idle(3);
        chk("badcs_err", bus.err, 1'b1);
        chk("badcs_cpu_rst", bus.cpu_rst, 1'b1);
        chk("badcs_done", bus.done, 1'b0);

        // Zero length
        wlog.delete();
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        idle(3);
        chk("zero_done", bus.done, 1'b1);
        chk("zero_cpu_rst", bus.cpu_rst, 1'b0);
        chk("zero_wr_count", wlog.size(), 0);

        // Oversize length
        fr = '{8'hA5, 8'h01, 8'h04};
        send_frame(fr);
        idle(3);
        chk("oversize_err", bus.err, 1'b1);
        chk("model_oversize_err", exp_err, 1'b1);

        // Timeout inside a frame
        wlog.delete();
        fr = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_frame(fr);
        idle(T - 1);
        chk("tmo_not_yet", bus.err, 1'b0);
        idle(2);
        chk("tmo_err", bus.err, 1'b1);
        chk("tmo_wr_count", wlog.size(), 0);

        // Garbage in IDLE, good frame, then reload from DONE
        send(8'h11, 2);
        send(8'h5A, 2);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        idle(2);
        wlog.delete();
        send(8'hA5, 0);
        chk("reload_cpu_rst_hi", bus.cpu_rst, 1'b1);
        idle(2);
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(fr);
        idle(3);
        chk("reload_done", bus.done, 1'b1);
        chk("reload_wr_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("reload_wr_data", wlog[0].data, 32'hDDCC_BBAA);

        // Asynchronous reset in mid-frame
        fr = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
        send_frame(fr);
        idle(1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_cpu_rst", bus.cpu_rst, 1'b1);
        chk("arst_mem_load", bus.mem_load, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_err", bus.err, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            n    = $urandom_range(0, 4);
            fr.delete();
            cs = 8'h00;
            if (kind == 0) begin
                for (int i = 0; i < 3; i++) fr.push_back(8'($urandom_range(0, 255)));
            end else begin
                fr.push_back(MG);
                if (kind == 1) begin
                    fr.push_back(8'($urandom_range(1, 255)));
                    fr.push_back(8'h04);
                end else begin
                    fr.push_back(8'(n));
                    fr.push_back(8'h00);
                    for (int i = 0; i < 4 * int'(n); i++) begin
                        fr.push_back(8'($urandom_range(0, 255)));
                        cs = cs ^ fr[fr.size() - 1];
                    end
                    fr.push_back((kind == 2) ? ~cs : cs);
                end
            end
            cut = (kind == 3) ? $urandom_range(1, fr.size() - 1) : fr.size();
            for (int i = 0; i < int'(cut); i++) send(fr[i], $urandom_range(1, 3));
            if (kind == 3) idle(T + 3);
            else idle($urandom_range(1, 4));
        end

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
